// File: rtl/apb_gpio_ctrl_pkg.sv
// Shared constants for the APB GPIO controller.
//   MAX_PINS      widest pin count the register map can hold (one 32-bit word)
//   GPIO_*        byte offsets of the registers within the block
package gpio_pkg;

  localparam int MAX_PINS = 32;

  localparam logic [31:0] GPIO_DOUT    = 32'h00;
  localparam logic [31:0] GPIO_DIR     = 32'h04;
  localparam logic [31:0] GPIO_DIN     = 32'h08;
  localparam logic [31:0] GPIO_AFSEL   = 32'h0C;
  localparam logic [31:0] GPIO_RISE_EN = 32'h10;
  localparam logic [31:0] GPIO_FALL_EN = 32'h14;
  localparam logic [31:0] GPIO_STAT    = 32'h18;

endpackage

// File: rtl/apb_gpio_ctrl_if.sv
// APB bus bundle between a master and the GPIO controller.
//   master: drives psel/penable/pwrite/paddr/pwdata, receives prdata/pready/pslverr
//   slave : the mirror image
interface apb_gpio_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_gpio_ctrl_sync_edge.sv
// One-pin input path: multi-flop synchroniser followed by an edge detector.
//   clk, rst  clock and async active-low reset
//   d         asynchronous pad input
//   q         synchronised value (last synchroniser stage)
//   rise/fall q changed 0->1 / 1->0 relative to the previous cycle
module gpio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign q    = sync[SYNC_STAGES-1];
  assign rise =  q & ~prev;
  assign fall = ~q &  prev;

endmodule

// File: rtl/apb_gpio_ctrl.sv
// APB slave GPIO controller: per-pin direction, alternate-function mux and a
// latched, maskable edge interrupt.
//   clk, rst          clock; async active-low reset (release expected synchronous to clk)
//   bus               APB slave port (zero wait states, pslverr on unmapped offsets)
//   gpio_in           asynchronous pad inputs
//   gpio_out/gpio_oe  pad output value / enable (1 = drive)
//   af_out/af_oe      peripheral-side output value / enable per pin
//   af_in             synchronised pin value handed to the peripheral
//   irq               level interrupt, high while any STAT bit is set
module apb_gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int NPINS       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 5
) (
  input  logic             clk,
  input  logic             rst,
  apb_gpio_ctrl_if.slave   bus,
  input  logic [NPINS-1:0] gpio_in,
  output logic [NPINS-1:0] gpio_out,
  output logic [NPINS-1:0] gpio_oe,
  input  logic [NPINS-1:0] af_out,
  input  logic [NPINS-1:0] af_oe,
  output logic [NPINS-1:0] af_in,
  output logic             irq
);

  logic [NPINS-1:0] dout, dir, afsel, rise_en, fall_en, stat;
  logic [NPINS-1:0] din, rise, fall;
  logic [NPINS-1:0] wdata, w1c, stat_set;
  logic [31:0]      reg_addr;
  logic             access, wr;
  logic [MAX_PINS-1:0] rd_bits;
  logic             hit;

  // ---------------- input path ----------------
  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (gpio_in[i]),
      .q    (din[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  // ---------------- APB decode ----------------
  // Only the word index selects a register; byte lanes within a word alias.
  assign reg_addr = 32'(bus.paddr) & ~32'd3;
  assign access   = bus.psel & bus.penable;
  assign wr       = access & bus.pwrite;
  assign wdata    = bus.pwdata[NPINS-1:0];

  // Edge set and W1C are merged so a same-cycle set always survives the clear.
  assign w1c      = (wr && reg_addr == GPIO_STAT) ? wdata : '0;
  assign stat_set = (rise & rise_en) | (fall & fall_en);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout    <= '0;
      dir     <= '0;
      afsel   <= '0;
      rise_en <= '0;
      fall_en <= '0;
      stat    <= '0;
    end else begin
      if (wr) begin
        case (reg_addr)
          GPIO_DOUT:    dout    <= wdata;
          GPIO_DIR:     dir     <= wdata;
          GPIO_AFSEL:   afsel   <= wdata;
          GPIO_RISE_EN: rise_en <= wdata;
          GPIO_FALL_EN: fall_en <= wdata;
          default: ;
        endcase
      end
      stat <= (stat & ~w1c) | stat_set;
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    rd_bits = '0;
    hit     = 1'b1;
    case (reg_addr)
      GPIO_DOUT:    rd_bits = MAX_PINS'(dout);
      GPIO_DIR:     rd_bits = MAX_PINS'(dir);
      GPIO_DIN:     rd_bits = MAX_PINS'(din);
      GPIO_AFSEL:   rd_bits = MAX_PINS'(afsel);
      GPIO_RISE_EN: rd_bits = MAX_PINS'(rise_en);
      GPIO_FALL_EN: rd_bits = MAX_PINS'(fall_en);
      GPIO_STAT:    rd_bits = MAX_PINS'(stat);
      default:      hit     = 1'b0;
    endcase
  end

  // Gating with rst keeps the bus quiet while reset is held, even mid-access.
  assign bus.prdata  = (access && rst) ? 32'(rd_bits) : 32'd0;
  assign bus.pslverr = access & rst & ~hit;
  assign bus.pready  = 1'b1;

  // ---------------- pin mux ----------------
  assign gpio_out = (afsel & af_out) | (~afsel & dout);
  assign gpio_oe  = (afsel & af_oe)  | (~afsel & dir);
  assign af_in    = din;
  assign irq      = |stat;

endmodule
